// File: rtl/priv_trap_sequencer.sv
// rtl/priv_trap_sequencer.sv - trap entry / xRET sequencer between hazard unit and CSR file
// Optional feature: TRAP_DELEG_EN (exception delegation to S-mode via medeleg/stvec).
module priv_trap_sequencer #(
    parameter int WORD_W  = 32,
    parameter int CAUSE_W = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [11:0]       exc_vec,
    input  logic              mret,
    input  logic              sret,
    input  logic [WORD_W-1:0] epc,
    input  logic [WORD_W-1:0] badaddr,
    input  logic              pipe_clear,
    input  logic              timer_int,
    input  logic              soft_int,
    input  logic              ext_int,
    input  logic              mstatus_mie,
    input  logic [1:0]        curr_priv,
    input  logic [WORD_W-1:0] mtvec,
    input  logic [WORD_W-1:0] stvec,
    input  logic [WORD_W-1:0] mepc,
    input  logic [WORD_W-1:0] sepc,
    input  logic [15:0]       medeleg,
    output logic              intr,
    output logic              insert_pc,
    output logic [WORD_W-1:0] priv_pc,
    output logic              trap_valid,
    output logic [WORD_W-1:0] trap_cause,
    output logic [WORD_W-1:0] trap_epc,
    output logic [WORD_W-1:0] trap_tval,
    output logic              trap_to_s,
    output logic              xret_valid,
    output logic              xret_is_s
);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        COMMIT,
        RET_DRAIN,
        RET_COMMIT
    } state_t;

    state_t              state, state_d;
    logic                intr_d, insert_d, tvalid_d, xvalid_d;
    logic [WORD_W-1:0]   pc_d;
    logic                latch_exc, latch_irq, latch_ret;
    logic [CAUSE_W-1:0]  exc_code, irq_code;
    logic                irq_take, exc_deleg;
    logic [WORD_W-1:0]   tvec, trap_target;

    // exc_vec: {fsp,flp,fip,env,bkpt,mal_s,fault_s,mal_l,fault_l,illegal,mal_insn,fault_insn}
    always_comb begin
        exc_code = '0;
        if (exc_vec[7])       exc_code = CAUSE_W'(3);
        else if (exc_vec[9])  exc_code = CAUSE_W'(12);
        else if (exc_vec[0])  exc_code = CAUSE_W'(1);
        else if (exc_vec[2])  exc_code = CAUSE_W'(2);
        else if (exc_vec[1])  exc_code = CAUSE_W'(0);
        else if (exc_vec[8])  exc_code = CAUSE_W'(8) + CAUSE_W'(curr_priv);
        else if (exc_vec[6])  exc_code = CAUSE_W'(6);
        else if (exc_vec[4])  exc_code = CAUSE_W'(4);
        else if (exc_vec[11]) exc_code = CAUSE_W'(15);
        else if (exc_vec[10]) exc_code = CAUSE_W'(13);
        else if (exc_vec[5])  exc_code = CAUSE_W'(7);
        else if (exc_vec[3])  exc_code = CAUSE_W'(5);
    end

    always_comb begin
        irq_code = CAUSE_W'(7);
        if (ext_int)       irq_code = CAUSE_W'(11);
        else if (soft_int) irq_code = CAUSE_W'(3);
    end

    assign irq_take = (ext_int | soft_int | timer_int) & (mstatus_mie | (curr_priv != 2'b11));

`ifdef TRAP_DELEG_EN
    assign exc_deleg = medeleg[exc_code[3:0]] & (curr_priv != 2'b11);
    assign tvec      = trap_to_s ? stvec : mtvec;
`else
    logic unused_cfg;
    assign unused_cfg = ^{medeleg, stvec};
    assign exc_deleg  = 1'b0;
    assign tvec       = mtvec;
`endif

    // Vectored mode only offsets interrupts; exceptions always land on the base.
    always_comb begin
        trap_target = {tvec[WORD_W-1:2], 2'b00};
        if (tvec[1:0] == 2'b01 && trap_cause[WORD_W-1])
            trap_target = trap_target + (WORD_W'(trap_cause[CAUSE_W-1:0]) << 2);
    end

    always_comb begin
        state_d   = state;
        intr_d    = 1'b0;
        insert_d  = 1'b0;
        tvalid_d  = 1'b0;
        xvalid_d  = 1'b0;
        pc_d      = '0;
        latch_exc = 1'b0;
        latch_irq = 1'b0;
        latch_ret = 1'b0;
        case (state)
            IDLE: begin
                if (|exc_vec) begin
                    latch_exc = 1'b1;
                    intr_d    = 1'b1;
                    state_d   = DRAIN;
                end else if (irq_take) begin
                    latch_irq = 1'b1;
                    intr_d    = 1'b1;
                    state_d   = DRAIN;
                end else if (mret | sret) begin
                    latch_ret = 1'b1;
                    intr_d    = 1'b1;
                    state_d   = RET_DRAIN;
                end
            end
            DRAIN: begin
                intr_d = 1'b1;
                if (pipe_clear) begin
                    state_d  = COMMIT;
                    insert_d = 1'b1;
                    tvalid_d = 1'b1;
                    pc_d     = trap_target;
                end
            end
            RET_DRAIN: begin
                intr_d = 1'b1;
                if (pipe_clear) begin
                    state_d  = RET_COMMIT;
                    insert_d = 1'b1;
                    xvalid_d = 1'b1;
                    pc_d     = xret_is_s ? sepc : mepc;
                end
            end
            COMMIT:     state_d = IDLE;
            RET_COMMIT: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            intr       <= 1'b0;
            insert_pc  <= 1'b0;
            trap_valid <= 1'b0;
            xret_valid <= 1'b0;
            priv_pc    <= '0;
        end else begin
            state      <= state_d;
            intr       <= intr_d;
            insert_pc  <= insert_d;
            trap_valid <= tvalid_d;
            xret_valid <= xvalid_d;
            priv_pc    <= pc_d;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            trap_cause <= '0;
            trap_epc   <= '0;
            trap_tval  <= '0;
            trap_to_s  <= 1'b0;
            xret_is_s  <= 1'b0;
        end else if (latch_exc) begin
            trap_cause <= WORD_W'(exc_code);
            trap_epc   <= epc;
            trap_tval  <= badaddr;
            trap_to_s  <= exc_deleg;
        end else if (latch_irq) begin
            trap_cause <= {1'b1, (WORD_W-1)'(irq_code)};
            trap_epc   <= epc;
            trap_tval  <= '0;
            trap_to_s  <= 1'b0;
        end else if (latch_ret) begin
            // mret wins if both retire together
            xret_is_s  <= ~mret;
        end
    end

endmodule
